// File: rtl/hpd_event_ctrl.sv
// HPD event sequencer: capability read on plug-in, one status read per queued HPD IRQ,
// with retry/timeout, unplug abort and link-up/down indications. Optional: HPD_IRQ_COALESCE_EN.
module hpd_event_ctrl #(
  parameter int IRQ_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int RETRY_MAX      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hpd_detect,
  input  logic       hpd_irq,
  output logic       svc_req,
  output logic       svc_type,
  input  logic       svc_ack,
  input  logic       svc_done,
  input  logic       svc_err,
  output logic       link_up,
  output logic       link_down_pulse,
  output logic [3:0] irq_pending,
  output logic       irq_overflow,
  input  logic       irq_ovf_clr,
  output logic [2:0] ctrl_state
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
`ifdef HPD_IRQ_COALESCE_EN
  localparam logic [3:0] PEND_MAX = 4'd1;
`else
  localparam logic [3:0] PEND_MAX = 4'(IRQ_DEPTH);
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CAP_REQ   = 3'd1,
    S_CAP_WAIT  = 3'd2,
    S_CONNECTED = 3'd3,
    S_IRQ_REQ   = 3'd4,
    S_IRQ_WAIT  = 3'd5,
    S_ERROR     = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic            hpd_det_q, hpd_irq_q;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [3:0]      pending_q, pending_d;
  logic            ovf_q, ovf_d;
  logic            svc_req_q, svc_req_d;
  logic            svc_type_q, svc_type_d;
  logic            link_up_q, link_up_d;
  logic            link_down_q, link_down_d;

  logic det_rise, det_fall, irq_rise;
  logic svc_ok, svc_fail, irq_served, irq_count_en, ovf_drop;

  always_comb begin
    det_rise = hpd_detect & ~hpd_det_q;
    det_fall = ~hpd_detect & hpd_det_q;
    irq_rise = hpd_irq & ~hpd_irq_q;
    svc_ok   = svc_done & ~svc_err;
    svc_fail = svc_err | (tmo_q == TMO_LAST);

    state_d    = state_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    irq_served = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (det_rise) begin
          state_d = S_CAP_REQ;
          retry_d = '0;
        end
      end
      S_CAP_REQ: begin
        if (svc_ack) begin
          state_d = S_CAP_WAIT;
          tmo_d   = '0;
        end
      end
      S_IRQ_REQ: begin
        if (svc_ack) begin
          state_d = S_IRQ_WAIT;
          tmo_d   = '0;
        end
      end
      S_CAP_WAIT, S_IRQ_WAIT: begin
        if (svc_ok) begin
          state_d    = S_CONNECTED;
          retry_d    = '0;
          tmo_d      = '0;
          irq_served = (state_q == S_IRQ_WAIT);
        end else if (svc_fail) begin
          tmo_d = '0;
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + RW'(1);
            state_d = (state_q == S_CAP_WAIT) ? S_CAP_REQ : S_IRQ_REQ;
          end else begin
            state_d = S_ERROR;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CONNECTED: begin
        if (pending_q != 4'd0) begin
          state_d = S_IRQ_REQ;
          retry_d = '0;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    // Unplug overrides whatever the state logic above decided.
    if (det_fall) begin
      state_d    = S_IDLE;
      retry_d    = '0;
      tmo_d      = '0;
      irq_served = 1'b0;
    end
  end

  always_comb begin
    irq_count_en = irq_rise && (state_q != S_IDLE) && (state_q != S_ERROR);
    pending_d    = pending_q;
    ovf_drop     = 1'b0;

    // A rise and a completed service in the same cycle cancel out.
    if (irq_count_en && !irq_served) begin
      if (pending_q < PEND_MAX) pending_d = pending_q + 4'd1;
      else                      ovf_drop  = 1'b1;
    end else if (!irq_count_en && irq_served) begin
      pending_d = pending_q - 4'd1;
    end

    if (det_fall) begin
      pending_d = 4'd0;
      ovf_drop  = 1'b0;
    end

`ifdef HPD_IRQ_COALESCE_EN
    ovf_d = 1'b0;
`else
    ovf_d = ovf_q;
    if (irq_ovf_clr) ovf_d = 1'b0;
    if (ovf_drop)    ovf_d = 1'b1;
`endif
  end

  always_comb begin
    svc_req_d   = (state_d == S_CAP_REQ) || (state_d == S_IRQ_REQ);
    svc_type_d  = (state_d == S_IRQ_REQ);
    link_up_d   = (state_d == S_CONNECTED) || (state_d == S_IRQ_REQ) ||
                  (state_d == S_IRQ_WAIT);
    link_down_d = link_up_q & ~link_up_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hpd_det_q   <= 1'b0;
      hpd_irq_q   <= 1'b0;
      retry_q     <= '0;
      tmo_q       <= '0;
      pending_q   <= 4'd0;
      ovf_q       <= 1'b0;
      svc_req_q   <= 1'b0;
      svc_type_q  <= 1'b0;
      link_up_q   <= 1'b0;
      link_down_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hpd_det_q   <= hpd_detect;
      hpd_irq_q   <= hpd_irq;
      retry_q     <= retry_d;
      tmo_q       <= tmo_d;
      pending_q   <= pending_d;
      ovf_q       <= ovf_d;
      svc_req_q   <= svc_req_d;
      svc_type_q  <= svc_type_d;
      link_up_q   <= link_up_d;
      link_down_q <= link_down_d;
    end
  end

  assign svc_req         = svc_req_q;
  assign svc_type        = svc_type_q;
  assign link_up         = link_up_q;
  assign link_down_pulse = link_down_q;
  assign irq_pending     = pending_q;
  assign irq_overflow    = ovf_q;
  assign ctrl_state      = state_q;

endmodule

// File: tb/tb_hpd_event_ctrl.sv
// Directed self-checking bench for hpd_event_ctrl: plug, IRQ servicing, overflow,
// retry/timeout into ERROR, unplug abort and reset mid-request.
module tb_hpd_event_ctrl;

  localparam int TMO = 24;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hpd_detect, hpd_irq;
  logic       svc_req, svc_type, svc_ack, svc_done, svc_err;
  logic       link_up, link_down_pulse;
  logic [3:0] irq_pending;
  logic       irq_overflow, irq_ovf_clr;
  logic [2:0] ctrl_state;

  int total = 0;
  int bad   = 0;
  int req_total = 0;
  int irq_req_total = 0;
  logic req_prev = 1'b0;
  int base_req, base_irq;

  always #5 clk = ~clk;

  hpd_event_ctrl #(
    .IRQ_DEPTH(4),
    .TIMEOUT_CYCLES(TMO),
    .RETRY_MAX(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hpd_detect(hpd_detect),
    .hpd_irq(hpd_irq),
    .svc_req(svc_req),
    .svc_type(svc_type),
    .svc_ack(svc_ack),
    .svc_done(svc_done),
    .svc_err(svc_err),
    .link_up(link_up),
    .link_down_pulse(link_down_pulse),
    .irq_pending(irq_pending),
    .irq_overflow(irq_overflow),
    .irq_ovf_clr(irq_ovf_clr),
    .ctrl_state(ctrl_state)
  );

  // Count each new service request (rising edge of svc_req), split by type.
  always @(negedge clk) begin
    if (svc_req && !req_prev) begin
      req_total <= req_total + 1;
      if (svc_type) irq_req_total <= irq_req_total + 1;
    end
    req_prev <= svc_req;
  end

  // Hold the current inputs for n clock edges, then settle 1 time unit past the edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic pulseIrq();
    hpd_irq = 1'b1;
    applyStimulus(1);
    hpd_irq = 1'b0;
    applyStimulus(1);
  endtask

  initial begin
    rst_n = 1'b0; hpd_detect = 1'b0; hpd_irq = 1'b0;
    svc_ack = 1'b0; svc_done = 1'b0; svc_err = 1'b0; irq_ovf_clr = 1'b0;
    applyStimulus(2);
    checkOutput("rst_state", 8'(ctrl_state), 8'd0);
    checkOutput("rst_req", 8'(svc_req), 8'd0);
    checkOutput("rst_link", 8'(link_up), 8'd0);
    checkOutput("rst_pend", 8'(irq_pending), 8'd0);
    checkOutput("rst_ovf", 8'(irq_overflow), 8'd0);
    checkOutput("rst_ldp", 8'(link_down_pulse), 8'd0);
    rst_n = 1'b1;
    applyStimulus(1);
    checkOutput("idle_hold", 8'(ctrl_state), 8'd0);

    $display("[TB] plug and capability read");
    base_req = req_total;
    hpd_detect = 1'b1;
    applyStimulus(1);
    checkOutput("plug_state", 8'(ctrl_state), 8'd1);
    checkOutput("plug_req", 8'(svc_req), 8'd1);
    checkOutput("plug_type", 8'(svc_type), 8'd0);
    applyStimulus(1);
    checkOutput("plug_req_hold", 8'(svc_req), 8'd1);
    checkOutput("plug_type_hold", 8'(svc_type), 8'd0);
    svc_ack = 1'b1; applyStimulus(1); svc_ack = 1'b0;
    checkOutput("cap_wait_state", 8'(ctrl_state), 8'd2);
    checkOutput("cap_wait_req", 8'(svc_req), 8'd0);
    applyStimulus(4);
    checkOutput("cap_wait_link", 8'(link_up), 8'd0);
    svc_done = 1'b1; applyStimulus(1); svc_done = 1'b0;
    checkOutput("cap_ok_state", 8'(ctrl_state), 8'd3);
    checkOutput("cap_ok_link", 8'(link_up), 8'd1);
    checkOutput("cap_req_count", 8'(req_total - base_req), 8'd1);

    $display("[TB] IRQ servicing");
    base_irq = irq_req_total;
    hpd_irq = 1'b1; applyStimulus(1); hpd_irq = 1'b0;
    checkOutput("irq1_pend", 8'(irq_pending), 8'd1);
    checkOutput("irq1_state", 8'(ctrl_state), 8'd3);
    applyStimulus(1);
    checkOutput("irq_req_state", 8'(ctrl_state), 8'd4);
    checkOutput("irq_req_type", 8'(svc_type), 8'd1);
    svc_ack = 1'b1; applyStimulus(1); svc_ack = 1'b0;
    checkOutput("irq_wait_state", 8'(ctrl_state), 8'd5);
    applyStimulus(7);
    hpd_irq = 1'b1; applyStimulus(1); hpd_irq = 1'b0;
    checkOutput("irq2_pend", 8'(irq_pending), 8'd2);
    applyStimulus(4);
    svc_done = 1'b1; applyStimulus(1); svc_done = 1'b0;
    checkOutput("irq_done1_pend", 8'(irq_pending), 8'd1);
    checkOutput("irq_done1_state", 8'(ctrl_state), 8'd3);
    applyStimulus(1);
    checkOutput("irq_req2_type", 8'(svc_type), 8'd1);
    svc_ack = 1'b1; applyStimulus(1); svc_ack = 1'b0;
    applyStimulus(2);
    svc_done = 1'b1; hpd_irq = 1'b1; applyStimulus(1); svc_done = 1'b0; hpd_irq = 1'b0;
    checkOutput("irq_cancel_pend", 8'(irq_pending), 8'd1);
    applyStimulus(1);
    checkOutput("irq_req3_state", 8'(ctrl_state), 8'd4);
    svc_ack = 1'b1; applyStimulus(1); svc_ack = 1'b0;
    svc_done = 1'b1; applyStimulus(1); svc_done = 1'b0;
    checkOutput("irq_drain_pend", 8'(irq_pending), 8'd0);
    applyStimulus(2);
    checkOutput("irq_idle_conn", 8'(ctrl_state), 8'd3);
    checkOutput("irq_req_count", 8'(irq_req_total - base_irq), 8'd3);

    $display("[TB] IRQ overflow");
    for (int i = 0; i < 4; i++) pulseIrq();
    checkOutput("ovf_full_pend", 8'(irq_pending), 8'd4);
    checkOutput("ovf_full_flag", 8'(irq_overflow), 8'd0);
    pulseIrq();
    pulseIrq();
    checkOutput("ovf_pend", 8'(irq_pending), 8'd4);
    checkOutput("ovf_flag", 8'(irq_overflow), 8'd1);
    checkOutput("ovf_req_held", 8'(svc_req), 8'd1);
    irq_ovf_clr = 1'b1; applyStimulus(1); irq_ovf_clr = 1'b0;
    checkOutput("ovf_clr_flag", 8'(irq_overflow), 8'd0);
    checkOutput("ovf_clr_pend", 8'(irq_pending), 8'd4);
    irq_ovf_clr = 1'b1; hpd_irq = 1'b1; applyStimulus(1); irq_ovf_clr = 1'b0; hpd_irq = 1'b0;
    checkOutput("ovf_clr_vs_set", 8'(irq_overflow), 8'd1);
    irq_ovf_clr = 1'b1; applyStimulus(1); irq_ovf_clr = 1'b0;
    checkOutput("ovf_clr2_flag", 8'(irq_overflow), 8'd0);

    $display("[TB] unplug during IRQ wait");
    svc_ack = 1'b1; applyStimulus(1); svc_ack = 1'b0;
    svc_done = 1'b1; applyStimulus(1); svc_done = 1'b0;
    checkOutput("drain_pend3", 8'(irq_pending), 8'd3);
    applyStimulus(1);
    svc_ack = 1'b1; applyStimulus(1); svc_ack = 1'b0;
    svc_done = 1'b1; applyStimulus(1); svc_done = 1'b0;
    checkOutput("drain_pend2", 8'(irq_pending), 8'd2);
    applyStimulus(1);
    svc_ack = 1'b1; applyStimulus(1); svc_ack = 1'b0;
    checkOutput("unplug_pre_state", 8'(ctrl_state), 8'd5);
    hpd_detect = 1'b0; applyStimulus(1);
    checkOutput("unplug_state", 8'(ctrl_state), 8'd0);
    checkOutput("unplug_req", 8'(svc_req), 8'd0);
    checkOutput("unplug_pend", 8'(irq_pending), 8'd0);
    checkOutput("unplug_link", 8'(link_up), 8'd0);
    checkOutput("unplug_ldp", 8'(link_down_pulse), 8'd1);
    applyStimulus(1);
    checkOutput("unplug_ldp_end", 8'(link_down_pulse), 8'd0);
    svc_done = 1'b1; applyStimulus(1); svc_done = 1'b0;
    checkOutput("late_done_state", 8'(ctrl_state), 8'd0);
    checkOutput("late_done_link", 8'(link_up), 8'd0);
    hpd_irq = 1'b1; applyStimulus(1); hpd_irq = 1'b0;
    checkOutput("idle_irq_ignored", 8'(irq_pending), 8'd0);
    applyStimulus(1);

    $display("[TB] retry on error");
    base_req = req_total;
    hpd_detect = 1'b1; applyStimulus(1);
    checkOutput("retry_start", 8'(ctrl_state), 8'd1);
    for (int i = 0; i < 3; i++) begin
      svc_ack = 1'b1; applyStimulus(1); svc_ack = 1'b0;
      applyStimulus(2);
      svc_err = 1'b1;
      if (i == 2) svc_done = 1'b1;
      applyStimulus(1);
      svc_err = 1'b0; svc_done = 1'b0;
      checkOutput("retry_back_to_req", 8'(ctrl_state), 8'd1);
    end
    svc_ack = 1'b1; applyStimulus(1); svc_ack = 1'b0;
    svc_done = 1'b1; applyStimulus(1); svc_done = 1'b0;
    checkOutput("retry_ok_state", 8'(ctrl_state), 8'd3);
    checkOutput("retry_ok_link", 8'(link_up), 8'd1);
    checkOutput("retry_req_count", 8'(req_total - base_req), 8'd4);

    $display("[TB] timeout into ERROR");
    hpd_detect = 1'b0; applyStimulus(1);
    checkOutput("tmo_unplug_ldp", 8'(link_down_pulse), 8'd1);
    applyStimulus(1);
    base_req = req_total;
    hpd_detect = 1'b1; applyStimulus(1);
    svc_ack = 1'b1; applyStimulus(1); svc_ack = 1'b0;
    applyStimulus(TMO - 1);
    checkOutput("tmo_not_yet", 8'(ctrl_state), 8'd2);
    applyStimulus(1);
    checkOutput("tmo_retry", 8'(ctrl_state), 8'd1);
    for (int i = 0; i < 3; i++) begin
      svc_ack = 1'b1; applyStimulus(1); svc_ack = 1'b0;
      applyStimulus(TMO);
    end
    checkOutput("err_state", 8'(ctrl_state), 8'd6);
    checkOutput("err_req", 8'(svc_req), 8'd0);
    checkOutput("err_link", 8'(link_up), 8'd0);
    checkOutput("tmo_req_count", 8'(req_total - base_req), 8'd4);
    applyStimulus(5);
    checkOutput("err_sticky", 8'(ctrl_state), 8'd6);
    pulseIrq();
    checkOutput("err_irq_ignored", 8'(irq_pending), 8'd0);
    hpd_detect = 1'b0; applyStimulus(1);
    checkOutput("err_exit_state", 8'(ctrl_state), 8'd0);
    checkOutput("err_exit_ldp", 8'(link_down_pulse), 8'd0);
    applyStimulus(1);

    $display("[TB] reset during capability request");
    hpd_detect = 1'b1; applyStimulus(1);
    checkOutput("rst_mid_pre", 8'(svc_req), 8'd1);
    rst_n = 1'b0; applyStimulus(1); rst_n = 1'b1;
    checkOutput("rst_mid_state", 8'(ctrl_state), 8'd0);
    checkOutput("rst_mid_req", 8'(svc_req), 8'd0);
    checkOutput("rst_mid_link", 8'(link_up), 8'd0);
    applyStimulus(1);
    checkOutput("rst_replug_state", 8'(ctrl_state), 8'd1);
    checkOutput("rst_replug_req", 8'(svc_req), 8'd1);
    checkOutput("rst_replug_type", 8'(svc_type), 8'd0);
    svc_ack = 1'b1; applyStimulus(1); svc_ack = 1'b0;
    svc_done = 1'b1; applyStimulus(1); svc_done = 1'b0;
    checkOutput("rst_replug_link", 8'(link_up), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
